// File: rtl/fir_coef_loader.sv
// ============================================================================
// fir_coef_loader: streams NTAPS coefficients into fir_transpose, then reads
// every tap back and checks it against a shadow copy.  Rev 1.0
// ============================================================================
`default_nettype none

module fir_coef_loader #(
  parameter int NTAPS  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        coef_valid,
  input  logic [11:0] coef_data,
  output logic        coef_ready,
  output logic        load,
  output logic [7:0]  write_address,
  output logic [11:0] write_value,
  output logic [7:0]  read_address,
  input  logic [11:0] read_value,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_address
);

  localparam int         c_aw    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [8:0] c_ntaps = 9'(NTAPS);
  localparam logic [8:0] c_vlast = 9'(NTAPS + RD_LAT - 1);
  localparam logic [8:0] c_rdlat = 9'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t      r_state;
  logic [8:0]  r_wr_cnt;
  logic [8:0]  r_vcnt;
  logic [11:0] r_shadow [0:(1 << c_aw) - 1];

  logic        w_accept;
  logic [7:0]  w_cmp_addr;
  logic        w_cmp_en;
  logic        w_cmp_bad;

  assign w_accept   = (r_state == S_LOAD) && coef_ready && coef_valid;
  assign w_cmp_addr = 8'(r_vcnt - c_rdlat);
  assign w_cmp_en   = (r_state == S_VERIFY) && (r_vcnt >= c_rdlat);
  assign w_cmp_bad  = w_cmp_en && (read_value != r_shadow[w_cmp_addr[c_aw-1:0]]);

  always_ff @(posedge clk) begin
    if (w_accept) r_shadow[r_wr_cnt[c_aw-1:0]] <= coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_cnt      <= 9'd0;
      r_vcnt        <= 9'd0;
      coef_ready    <= 1'b0;
      load          <= 1'b0;
      write_address <= 8'd0;
      write_value   <= 12'd0;
      read_address  <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_address   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_wr_cnt    <= 9'd0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_address <= 8'd0;
            load        <= 1'b1;
            coef_ready  <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            write_address <= r_wr_cnt[7:0];
            write_value   <= coef_data;
            r_wr_cnt      <= r_wr_cnt + 9'd1;
            if (r_wr_cnt == c_ntaps - 9'd1) coef_ready <= 1'b0;
          end
          // Last tap is on the write port this cycle; FIR captures it next edge.
          if (r_wr_cnt == c_ntaps) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_state      <= S_VERIFY;
          load         <= 1'b0;
          r_vcnt       <= 9'd0;
          read_address <= 8'd0;
        end
        S_VERIFY: begin
          r_vcnt <= r_vcnt + 9'd1;
          if (r_vcnt + 9'd1 < c_ntaps) read_address <= 8'(r_vcnt + 9'd1);
          if (w_cmp_bad) begin
            r_state      <= S_ERROR;
            error        <= 1'b1;
            err_address  <= w_cmp_addr;
            busy         <= 1'b0;
            read_address <= 8'd0;
          end else if (r_vcnt == c_vlast) begin
            r_state      <= S_DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            read_address <= 8'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// ============================================================================
// tb_fir_coef_loader: loader driven against a behavioural FIR coefficient bank
// and an event-timeline reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fir_coef_loader;

  localparam int NTAPS  = 8;
  localparam int RD_LAT = 1;

  typedef logic [11:0] vec_t [NTAPS];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        coef_valid = 1'b0;
  logic [11:0] coef_data = 12'd0;
  logic [11:0] read_value = 12'd0;
  logic        coef_ready, load, busy, done, error;
  logic [7:0]  write_address, read_address, err_address;
  logic [11:0] write_value;
  logic        inject = 1'b0;

  always #5 clk = ~clk;

  fir_coef_loader #(.NTAPS(NTAPS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_valid(coef_valid),
    .coef_data(coef_data), .coef_ready(coef_ready), .load(load),
    .write_address(write_address), .write_value(write_value),
    .read_address(read_address), .read_value(read_value), .busy(busy),
    .done(done), .error(error), .err_address(err_address)
  );

  // Behavioural coefficient bank of the filter, one-cycle readback.
  logic [11:0] fir_mem [256];
  initial for (int k = 0; k < 256; k++) fir_mem[k] = 12'd0;
  always @(posedge clk) begin
    if (load) fir_mem[write_address] <= write_value;
    read_value <= fir_mem[read_address] ^ ((inject && read_address == 8'd5) ? 12'h001 : 12'h000);
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int load_total = 0;
  int done_rises = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (load === 1'b1) load_total++;
    if (done === 1'b1 && prev_done !== 1'b1) done_rises++;
    prev_done = done;
  end

  // Reference model: phases driven by event edges (start, accepts, timeline offsets).
  // 0 idle, 1 loading, 2 draining, 3 verifying, 4 done, 5 error
  int         m_ph = 0, m_acc = 0, m_edge = 0, m_last = 0, m_vstart = 0, m_end = 0, m_bad = 0;
  logic [7:0]  e_wa = 8'd0, e_ea = 8'd0;
  logic [11:0] e_wv = 12'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_acc = 0; e_wa = 8'd0; e_wv = 12'd0; e_ea = 8'd0;
    end else begin
      m_edge++;
      case (m_ph)
        0, 4, 5: if (start) begin m_ph = 1; m_acc = 0; e_ea = 8'd0; end
        1: if (coef_valid) begin
             e_wa = 8'(m_acc); e_wv = coef_data; m_acc++;
             if (m_acc == NTAPS) begin m_ph = 2; m_last = m_edge; end
           end
        2: if (m_edge == m_last + 2) begin
             m_ph = 3; m_vstart = m_edge;
             m_bad = inject ? 5 : NTAPS;
             m_end = m_vstart + ((m_bad < NTAPS) ? m_bad + RD_LAT + 1 : NTAPS + RD_LAT);
           end
        3: if (m_edge == m_end) begin
             if (m_bad < NTAPS) begin m_ph = 5; e_ea = 8'(m_bad); end
             else m_ph = 4;
           end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int j;
    int ra;
    j  = m_edge - m_vstart;
    ra = (m_ph == 3) ? ((j < NTAPS) ? j : NTAPS - 1) : 0;
    chk("coef_ready", coef_ready, m_ph == 1);
    chk("load", load, m_ph == 1 || m_ph == 2);
    chk("busy", busy, m_ph >= 1 && m_ph <= 3);
    chk("done", done, m_ph == 4);
    chk("error", error, m_ph == 5);
    chk("err_address", err_address, e_ea);
    chk("write_address", write_address, e_wa);
    chk("write_value", write_value, e_wv);
    chk("read_address", read_address, ra);
  end

  int e_start = 0, l0 = 0, r0 = 0;

  task automatic pulse_start(input bit with_valid);
    @(posedge clk); #2;
    start = 1'b1;
    if (with_valid) begin coef_valid = 1'b1; coef_data = 12'hFFF; end
    @(posedge clk); #2;
    start = 1'b0; coef_valid = 1'b0;
    e_start = cyc; l0 = load_total; r0 = done_rises;
  endtask

  task automatic stream(input vec_t v, input int n, input int gap_after, input int gap_len, input int pct);
    int  i = 0;
    int  guard = 0;
    int  gl = gap_len;
    logic rdy;
    while (i < n && guard < 1000) begin
      guard++;
      if (i == gap_after && gl > 0) begin
        coef_valid = 1'b0;
        repeat (gl) begin @(posedge clk); #2; end
        gl = 0;
      end else if (pct > 0 && $urandom_range(99) < pct) begin
        coef_valid = 1'b0; coef_data = 12'($urandom);
        @(posedge clk); #2;
      end else begin
        coef_valid = 1'b1; coef_data = v[i]; rdy = coef_ready;
        @(posedge clk); #2;
        if (rdy) i++;
      end
    end
    coef_valid = 1'b0;
    chk("stream_accepts", i, n);
  endtask

  task automatic wait_end(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) begin lat = cyc - e_start; break; end
    end
    if (lat < 0) chk("end_timeout", 0, 1);
  endtask

  task automatic chk_taps(input vec_t v);
    for (int k = 0; k < NTAPS; k++) chk("fir_tap", fir_mem[k], v[k]);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t v, v2;
    int lat;
    for (int k = 0; k < NTAPS; k++) begin v[k] = 12'(k + 1); v2[k] = 12'(NTAPS - k); end

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    rst_n = 1'b1;

    // Clean load, with a coefficient offered alongside start (must not be taken)
    pulse_start(1'b1);
    stream(v, NTAPS, -1, 0, 0);
    wait_end(lat);
    chk("clean_latency", lat, 19);
    chk("clean_done", done, 1);
    chk("clean_error", error, 0);
    chk("clean_load_cycles", load_total - l0, 10);
    chk_taps(v);

    // Stalled stream
    pulse_start(1'b0);
    stream(v, NTAPS, 4, 3, 0);
    wait_end(lat);
    chk("stall_latency", lat, 22);
    chk("stall_load_cycles", load_total - l0, 13);

    // Start during VERIFY is ignored
    pulse_start(1'b0);
    stream(v, NTAPS, -1, 0, 0);
    repeat (4) begin @(posedge clk); #2; end
    start = 1'b1; @(posedge clk); #2; start = 1'b0;
    wait_end(lat);
    chk("verify_start_latency", lat, 19);
    repeat (4) @(posedge clk);
    chk("verify_start_done_once", done_rises - r0, 1);

    // Offered coefficient in DONE: no write, load low
    @(posedge clk); #2;
    coef_valid = 1'b1; coef_data = 12'hFFF;
    repeat (4) begin @(negedge clk); chk("done_valid_load", load, 0); end
    coef_valid = 1'b0;
    chk_taps(v);

    // Readback mismatch at tap 5
    inject = 1'b1;
    pulse_start(1'b0);
    stream(v, NTAPS, -1, 0, 0);
    wait_end(lat);
    chk("mm_latency", lat, 17);
    chk("mm_error", error, 1);
    chk("mm_err_address", err_address, 5);
    chk("mm_done", done, 0);
    inject = 1'b0;

    // Restart from ERROR with reversed values
    pulse_start(1'b0);
    @(negedge clk);
    chk("restart_error_clear", error, 0);
    stream(v2, NTAPS, -1, 0, 0);
    wait_end(lat);
    chk("restart_latency", lat, 19);
    chk("restart_done", done, 1);
    chk_taps(v2);

    // Reset mid-stream, then reload
    pulse_start(1'b0);
    stream(v, 3, -1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", coef_ready, 0);
    chk("midrst_wa", write_address, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pulse_start(1'b0);
    stream(v, NTAPS, -1, 0, 0);
    wait_end(lat);
    chk("postrst_latency", lat, 19);
    chk_taps(v);

    // Randomized runs: random data, random stalls, random readback fault
    for (int r = 0; r < 8; r++) begin
      vec_t vr;
      for (int k = 0; k < NTAPS; k++) vr[k] = 12'($urandom);
      inject = 1'($urandom_range(1));
      pulse_start(1'($urandom_range(1)));
      stream(vr, NTAPS, -1, 0, 30);
      wait_end(lat);
      if (inject) chk("rand_err_address", err_address, 5);
      else        chk("rand_done", done, 1);
      chk_taps(vr);
      inject = 1'b0;
      repeat ($urandom_range(3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
